// File: rtl/register_file.sv
// 128 x 128-bit register file: six registered read ports, two write ports (odd wins on collision).
// Optional macro RF_WRITE_BYPASS_EN forwards same-cycle write data to matching reads.
module register_file (
  input  logic         clk,
  input  logic         reset,
  input  logic [0:6]   ra_addr_even,
  input  logic [0:6]   rb_addr_even,
  input  logic [0:6]   rc_addr_even,
  input  logic [0:6]   ra_addr_odd,
  input  logic [0:6]   rb_addr_odd,
  input  logic [0:6]   rt_addr_odd,
  output logic [0:127] ra_even,
  output logic [0:127] rb_even,
  output logic [0:127] rc_even,
  output logic [0:127] ra_odd,
  output logic [0:127] rb_odd,
  output logic [0:127] rt_st_odd,
  input  logic [0:127] rt_wb_even,
  input  logic [0:6]   rt_addr_wb_even,
  input  logic         reg_write_wb_even,
  input  logic [0:127] rt_wb_odd,
  input  logic [0:6]   rt_addr_wb_odd,
  input  logic         reg_write_wb_odd,
  output logic         wr_conflict
);

  localparam int NREGS = 128;
  localparam int NRD   = 6;

  logic [0:127] mem_q     [NREGS];
  logic [0:127] mem_d     [NREGS];
  logic [0:127] rd_data_q [NRD];
  logic [0:127] rd_data_d [NRD];
  logic [0:6]   rd_addr   [NRD];
  logic         wr_conflict_q, wr_conflict_d;
  logic         collide, we_even, we_odd;

  assign rd_addr[0] = ra_addr_even;
  assign rd_addr[1] = rb_addr_even;
  assign rd_addr[2] = rc_addr_even;
  assign rd_addr[3] = ra_addr_odd;
  assign rd_addr[4] = rb_addr_odd;
  assign rd_addr[5] = rt_addr_odd;

  // On an equal-address dual write the even data is dropped entirely.
  always_comb begin
    collide       = reg_write_wb_even & reg_write_wb_odd &
                    (rt_addr_wb_even == rt_addr_wb_odd);
    we_even       = reg_write_wb_even & ~collide;
    we_odd        = reg_write_wb_odd;
    wr_conflict_d = collide;
  end

  always_comb begin
    mem_d = mem_q;
    if (we_even) mem_d[rt_addr_wb_even] = rt_wb_even;
    if (we_odd)  mem_d[rt_addr_wb_odd]  = rt_wb_odd;
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_data_d[i] = mem_q[rd_addr[i]];
`ifdef RF_WRITE_BYPASS_EN
      if (we_odd && (rt_addr_wb_odd == rd_addr[i]))
        rd_data_d[i] = rt_wb_odd;
      else if (we_even && (rt_addr_wb_even == rd_addr[i]))
        rd_data_d[i] = rt_wb_even;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
      for (int i = 0; i < NRD; i++)   rd_data_q[i] <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      rd_data_q     <= rd_data_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign ra_even     = rd_data_q[0];
  assign rb_even     = rd_data_q[1];
  assign rc_even     = rd_data_q[2];
  assign ra_odd      = rd_data_q[3];
  assign rb_odd      = rd_data_q[4];
  assign rt_st_odd   = rd_data_q[5];
  assign wr_conflict = wr_conflict_q;

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL provide port: clk  input  1  single clock for all sequential logic, rising-edge.
REQ-002 SHALL provide port: reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-003 SHALL provide ports: ra_addr_even, rb_addr_even, rc_addr_even  input  7 each  even-pipe source register addresses, bit order [0:6].
REQ-004 SHALL provide ports: ra_addr_odd, rb_addr_odd, rt_addr_odd  input  7 each  odd-pipe source addresses; rt_addr_odd selects store data.
REQ-005 SHALL provide ports: ra_even, rb_even, rc_even  output  128 each  even-pipe operand values, bit order [0:127].
REQ-006 SHALL provide ports: ra_odd, rb_odd, rt_st_odd  output  128 each  odd-pipe operand values; rt_st_odd feeds Local Store store data.
REQ-007 SHALL provide ports: rt_wb_even  input  128, rt_addr_wb_even  input  7, reg_write_wb_even  input  1  even-pipe writeback.
REQ-008 SHALL provide ports: rt_wb_odd  input  128, rt_addr_wb_odd  input  7, reg_write_wb_odd  input  1  odd-pipe writeback (Local Store and permute results).
REQ-009 SHALL provide port: wr_conflict  output  1  registered flag, both write ports targeted the same address in the previous cycle.

Function
REQ-010 SHALL hold 128 registers x 128 bits; register 0 is an ordinary register, not hardwired to zero.
REQ-011 SHALL sample all six read addresses on the rising edge of clk and present the six operand outputs registered, 1-cycle read latency.
REQ-012 SHALL write rt_wb_even to rt_addr_wb_even on the rising edge when reg_write_wb_even=1; likewise odd port when reg_write_wb_odd=1.
REQ-013 SHALL perform both writes in the same cycle when addresses differ.
REQ-014 SHALL, when both write enables are 1 and addresses are equal, store rt_wb_odd only; the even value is discarded.
REQ-015 SHALL set wr_conflict=1 for exactly the cycle following an equal-address dual write, else 0.
REQ-016 SHALL ignore rt_wb_* and rt_addr_wb_* contents when the matching reg_write_wb_* is 0.
REQ-017 SHALL allow any number of read ports to read the same address in one cycle, each receiving the identical value.
REQ-018 SHALL not stall, buffer, or back-pressure; one read set and up to two writes accepted every cycle.

Reset
REQ-019 SHALL, while reset=1, clear all 128 registers and drive ra_even, rb_even, rc_even, ra_odd, rb_odd, rt_st_odd and wr_conflict to 0, independent of clk.
REQ-020 SHALL ignore write enables during reset; writes arriving in the cycle reset deasserts take effect only on the first rising edge with reset=0.
REQ-021 SHALL abandon any in-flight read on reset; first valid operand appears one edge after the first post-reset address sample.

Configuration
REQ-022 SHALL support macro RF_WRITE_BYPASS_EN.
REQ-023 With RF_WRITE_BYPASS_EN defined: a read whose address equals an active same-cycle write address SHALL return the new write data (odd data when both ports match, per REQ-014).
REQ-024 Without RF_WRITE_BYPASS_EN: such a read SHALL return the pre-write register contents; the new value is visible to reads sampled on the following edge.

Verification
REQ-025 Reset: assert reset mid-run after writing 0xFF..FF to reg 5 -> all outputs 0 immediately; read reg 5 after release -> 0.
REQ-026 Basic write/read: write 128'h0011..EEFF to reg 3 via even port, next cycle ra_addr_odd=3 -> ra_odd=128'h0011..EEFF one cycle later.
REQ-027 Dual write distinct: even writes 0xA..A to reg 10, odd writes 0x5..5 to reg 11 same cycle -> later reads return 0xA..A and 0x5..5; wr_conflict stays 0.
REQ-028 Dual write collision: both ports write reg 20 (even 0x1..1, odd 0x2..2) -> reg 20 reads 0x2..2; wr_conflict=1 for one cycle only.
REQ-029 Bypass: write 0xDEAD..BEEF to reg 7 while rt_addr_odd=7 same cycle -> rt_st_odd=0xDEAD..BEEF with RF_WRITE_BYPASS_EN, old value without it.
REQ-030 Disabled write: reg_write_wb_odd=0 with rt_addr_wb_odd=9 and data 0x3..3 -> reg 9 unchanged.
